hazard_fwd_unit: RTL

- Central hazard and forwarding controller for the 5-stage 16-bit pipeline. It is the producer side of the EX stage's forward_aluin1/forward_aluin2 selects.
- Consumes per-instruction register-usage info from ID and keeps its own shadow pipeline of destination tags for EX, MEM and WB.
- Drives the EX operand selects, the IF/ID stall, the ID/EX bubble and the taken-branch flush.
- Counts stall cycles for performance debug.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/hazard_tag_stage.sv | 23 ++
 rtl/hazard_fwd_unit.sv | 104 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline hazard/forwarding logic: operand-select
// encodings, the per-stage destination tag record and the writer predicate.
package cpu_pkg;

    localparam int TAG_REG_W = 4;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;

    localparam logic [TAG_REG_W-1:0] REG_ZERO = '0;

    // Register-usage record carried alongside each instruction in EX/MEM/WB.
    typedef struct packed {
        logic                 valid;
        logic [TAG_REG_W-1:0] rs;
        logic [TAG_REG_W-1:0] rt;
        logic                 uses_rs;
        logic                 uses_rt;
        logic [TAG_REG_W-1:0] rd;
        logic                 regwrite;
        logic                 memread;
        logic                 flag_en;
    } tag_t;

    localparam tag_t TAG_BUBBLE = '0;

    // True when the stage holding t will write architectural register r.
    // R0 is hard-wired to zero, so a "write" to it never produces a value.
    function automatic logic tag_writes(input tag_t t, input logic [TAG_REG_W-1:0] r);
        return t.valid & t.regwrite & (t.rd == r) & (r != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_tag_stage.sv
// One stage of the shadow tag pipeline. A bubble request loads an invalid
// record instead of the upstream tag.
module hazard_tag_stage
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic bubble,
    input  tag_t d,
    output tag_t q
);

    // Tag register: cleared on reset, NOP-filled on bubble, otherwise shifts.
    always_ff @(posedge clk) begin
        if (rst)
            q <= TAG_BUBBLE;
        else if (bubble)
            q <= TAG_BUBBLE;
        else
            q <= d;
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for the 5-stage 16-bit pipeline.
// Keeps its own EX/MEM/WB tag pipeline, drives the EX operand selects, the
// front-end stall / ID-EX bubble / taken-branch flush, and a saturating
// stall-cycle counter.
module hazard_fwd_unit
    import cpu_pkg::*;
#(
    parameter int REG_W = TAG_REG_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_flag_en,
    input  logic             id_br_cond,
    input  logic             id_br_reg,
    input  logic             id_taken,
    output logic [1:0]       forward_aluin1,
    output logic [1:0]       forward_aluin2,
    output logic             stall,
    output logic             bubble,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cycles
);

    tag_t id_t, ex_t, mem_t, wb_t;
    logic load_use, flag_haz, br_haz;

    // Pack the ID-stage usage info into a tag; id_valid doubles as the tag valid.
    always_comb begin
        id_t          = TAG_BUBBLE;
        id_t.valid    = id_valid;
        id_t.rs       = TAG_REG_W'(id_rs);
        id_t.rt       = TAG_REG_W'(id_rt);
        id_t.uses_rs  = id_uses_rs;
        id_t.uses_rt  = id_uses_rt;
        id_t.rd       = TAG_REG_W'(id_rd);
        id_t.regwrite = id_regwrite;
        id_t.memread  = id_memread;
        id_t.flag_en  = id_flag_en;
    end

    // Only the entry into EX can be replaced by a bubble; downstream always shifts.
    hazard_tag_stage u_ex  (.clk(clk), .rst(rst), .bubble(stall), .d(id_t),  .q(ex_t));
    hazard_tag_stage u_mem (.clk(clk), .rst(rst), .bubble(1'b0),  .d(ex_t),  .q(mem_t));
    hazard_tag_stage u_wb  (.clk(clk), .rst(rst), .bubble(1'b0),  .d(mem_t), .q(wb_t));

    // Operand selects for the instruction in EX; the younger MEM result wins over WB.
    always_comb begin
        forward_aluin1 = FWD_NONE;
        forward_aluin2 = FWD_NONE;
        if (ex_t.valid && ex_t.uses_rs) begin
            if (tag_writes(mem_t, ex_t.rs))
                forward_aluin1 = FWD_MEM;
            else if (tag_writes(wb_t, ex_t.rs))
                forward_aluin1 = FWD_WB;
        end
        if (ex_t.valid && ex_t.uses_rt) begin
            if (tag_writes(mem_t, ex_t.rt))
                forward_aluin2 = FWD_MEM;
            else if (tag_writes(wb_t, ex_t.rt))
                forward_aluin2 = FWD_WB;
        end
    end

    // Hazard sources. A BR reads rs in ID, so it must wait out EX and MEM
    // writers; WB writers are covered by the register file's write-before-read.
    always_comb begin
        load_use = 1'b0;
        flag_haz = 1'b0;
        br_haz   = 1'b0;
        if (id_valid) begin
            load_use = ex_t.memread &
                       ((id_uses_rs & tag_writes(ex_t, id_t.rs)) |
                        (id_uses_rt & tag_writes(ex_t, id_t.rt)));
            flag_haz = id_br_cond & ex_t.valid & ex_t.flag_en;
            br_haz   = id_br_reg &
                       (tag_writes(ex_t, id_t.rs) | tag_writes(mem_t, id_t.rs));
        end
    end

    // A stalled taken branch has not really resolved yet, so it must not flush.
    always_comb begin
        stall  = load_use | flag_haz | br_haz;
        bubble = stall;
        flush  = id_taken & ~stall;
    end

    // Stall-cycle counter for performance debug; pins at all-ones.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (stall && (stall_cycles != {CNT_W{1'b1}}))
            stall_cycles <= stall_cycles + CNT_W'(1);
    end

endmodule
